// File: rtl/fifo_wr_ctrl_if.sv
// Write-side bundle of the async FIFO: producer push, RAM write port,
// read-pointer crossing and write-domain status flags.
interface fifo_wr_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic                  wr_req;
  logic [DATA_WIDTH-1:0] wr_data_in;
  logic                  ovf_clr;
  logic [ADDR_WIDTH:0]   rd_gptr_async;

  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [ADDR_WIDTH:0]   wr_gptr;
  logic                  full;
  logic                  almost_full;
  logic [ADDR_WIDTH:0]   wr_level;
  logic                  overflow;

  // master: the write controller; slave: producer, RAM and read domain
  modport master (
    input  wr_req, wr_data_in, ovf_clr, rd_gptr_async,
    output wr_en, wr_addr, wr_data, wr_gptr, full, almost_full, wr_level, overflow
  );

  modport slave (
    output wr_req, wr_data_in, ovf_clr, rd_gptr_async,
    input  wr_en, wr_addr, wr_data, wr_gptr, full, almost_full, wr_level, overflow
  );
endinterface

// File: rtl/fifo_wr_ctrl.sv
// Async FIFO write-side controller: binary/Gray write pointers, read-pointer
// synchroniser, zero-latency RAM write port and registered status flags.
module fifo_wr_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int AF_MARGIN  = 2
) (
  input  logic           wr_clk,
  input  logic           wr_rst_n,
  fifo_wr_ctrl_if.master bus
);

  localparam int AW    = ADDR_WIDTH;
  localparam int PW    = ADDR_WIDTH + 1;
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [PW-1:0] AF_LEVEL = PW'(DEPTH - AF_MARGIN);

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [PW-1:0] rd_gptr_s1_q, rd_gptr_s2_q;
  logic [PW-1:0] wr_bptr_q,    wr_bptr_d;
  logic [PW-1:0] wr_gptr_q,    wr_gptr_d;
  logic [PW-1:0] wr_level_q,   wr_level_d;
  logic          full_q,        full_d;
  logic          almost_full_q, almost_full_d;
  logic          overflow_q,    overflow_d;
  logic [PW-1:0] rd_bptr_s;
  logic [PW-1:0] full_match;
  logic          accept;

  // Two-flop synchroniser for the read-domain Gray pointer.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its source, which is what makes s1 -> s2 a real chain.
  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      rd_gptr_s1_q <= '0;
      rd_gptr_s2_q <= '0;
    end else begin
      rd_gptr_s1_q <= bus.rd_gptr_async;
      rd_gptr_s2_q <= rd_gptr_s1_q;
    end
  end

  // NOTE: every signal written here gets a value on every path (computed
  // unconditionally), so no latch can be inferred.
  always_comb begin
    // Gating with the reset keeps the RAM from seeing a write while reset is held.
    accept        = bus.wr_req & ~full_q & wr_rst_n;
    wr_bptr_d     = wr_bptr_q + PW'(accept);
    wr_gptr_d     = wr_bptr_d ^ (wr_bptr_d >> 1);
    rd_bptr_s     = gray2bin(rd_gptr_s2_q);
    full_match    = {~rd_gptr_s2_q[AW:AW-1], rd_gptr_s2_q[AW-2:0]};
    full_d        = (wr_gptr_d == full_match);
    wr_level_d    = wr_bptr_d - rd_bptr_s;
    almost_full_d = (wr_level_d >= AF_LEVEL);
    // A set in the same cycle as a clear wins.
    overflow_d    = (bus.wr_req & full_q) | (overflow_q & ~bus.ovf_clr);
  end

  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      wr_bptr_q     <= '0;
      wr_gptr_q     <= '0;
      wr_level_q    <= '0;
      full_q        <= 1'b0;
      almost_full_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      wr_bptr_q     <= wr_bptr_d;
      wr_gptr_q     <= wr_gptr_d;
      wr_level_q    <= wr_level_d;
      full_q        <= full_d;
      almost_full_q <= almost_full_d;
      overflow_q    <= overflow_d;
    end
  end

  // wr_gptr leaves straight from a flop: nothing glitchy crosses domains.
  assign bus.wr_en       = accept;
  assign bus.wr_addr     = wr_bptr_q[AW-1:0];
  assign bus.wr_data     = bus.wr_data_in;
  assign bus.wr_gptr     = wr_gptr_q;
  assign bus.full        = full_q;
  assign bus.almost_full = almost_full_q;
  assign bus.wr_level    = wr_level_q;
  assign bus.overflow    = overflow_q;

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Self-checking bench for fifo_wr_ctrl: fill table, hand-written corner
// sequences and a randomised run against a count-based occupancy model.
module tb_fifo_wr_ctrl;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int AFM   = 2;
  localparam int DEPTH = 1 << AW;
  localparam int PMOD  = 2 * DEPTH;

  typedef struct {
    logic          req;
    logic [DW-1:0] data;
    bit            exp_en;
    int            exp_addr;
    bit            exp_af;
    bit            exp_full;
    int            exp_level;
  } fill_vec_t;

  logic wr_clk = 1'b0;
  logic wr_rst_n;

  fifo_wr_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  fifo_wr_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AF_MARGIN(AFM)) dut (
    .wr_clk  (wr_clk),
    .wr_rst_n(wr_rst_n),
    .bus     (bus.master)
  );

  always #5 wr_clk = ~wr_clk;

  int n_vec = 0;
  int n_err = 0;

  // Model: pointers as plain counters; the read pointer reaches the flags
  // through a two-entry delay queue (newest at the front).
  int   m_wr;
  int   rd_ptr;
  int   m_level;
  bit   m_full, m_af, m_ovf;
  int   rd_sync[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [AW:0] to_gray(input int b);
    logic [AW:0] v;
    v = b[AW:0];
    return v ^ (v >> 1);
  endfunction

  task automatic model_reset();
    m_wr    = 0;
    m_level = 0;
    m_full  = 0;
    m_af    = 0;
    m_ovf   = 0;
    rd_sync = '{0, 0};
  endtask

  task automatic apply(input logic req, input logic [DW-1:0] data, input logic clr);
    bus.wr_req        = req;
    bus.wr_data_in    = data;
    bus.ovf_clr       = clr;
    bus.rd_gptr_async = to_gray(rd_ptr);
    #3;
  endtask

  task automatic clock_edge();
    int acc;
    @(posedge wr_clk);
    acc     = (bus.wr_req && !m_full) ? 1 : 0;
    m_ovf   = (bus.wr_req && m_full) || (m_ovf && !bus.ovf_clr);
    m_wr    = (m_wr + acc) % PMOD;
    m_level = (m_wr - rd_sync[1] + PMOD) % PMOD;
    m_full  = (m_level == DEPTH);
    m_af    = (m_level >= DEPTH - AFM);
    void'(rd_sync.pop_back());
    rd_sync.push_front(rd_ptr);
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".wr_en"},       32'(bus.wr_en),       32'(bus.wr_req && !m_full));
    check({tag, ".wr_addr"},     32'(bus.wr_addr),     32'(m_wr % DEPTH));
    check({tag, ".wr_data"},     32'(bus.wr_data),     32'(bus.wr_data_in));
    check({tag, ".wr_gptr"},     32'(bus.wr_gptr),     32'(to_gray(m_wr)));
    check({tag, ".full"},        32'(bus.full),        32'(m_full));
    check({tag, ".almost_full"}, 32'(bus.almost_full), 32'(m_af));
    check({tag, ".wr_level"},    32'(bus.wr_level),    32'(m_level));
    check({tag, ".overflow"},    32'(bus.overflow),    32'(m_ovf));
  endtask

  task automatic check_cleared(input string tag);
    check({tag, ".wr_en"},       32'(bus.wr_en),       0);
    check({tag, ".wr_addr"},     32'(bus.wr_addr),     0);
    check({tag, ".wr_gptr"},     32'(bus.wr_gptr),     0);
    check({tag, ".full"},        32'(bus.full),        0);
    check({tag, ".almost_full"}, 32'(bus.almost_full), 0);
    check({tag, ".wr_level"},    32'(bus.wr_level),    0);
    check({tag, ".overflow"},    32'(bus.overflow),    0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    fill_vec_t   tbl [DEPTH];
    logic [AW:0] prev_g, cur_g;
    logic [AW:0] gptr_at_full;
    int          last_addr, occ;
    bit          seen_addr_wrap, seen_ptr_wrap, seen_full;
    bit          drain_full [3];
    bit          drain_af   [3];

    for (int i = 0; i < DEPTH; i++) begin
      tbl[i].req       = 1'b1;
      tbl[i].data      = 8'hA0 + 8'(i);
      tbl[i].exp_en    = 1'b1;
      tbl[i].exp_addr  = i;
      tbl[i].exp_level = i + 1;
      tbl[i].exp_af    = (i + 1) >= DEPTH - AFM;
      tbl[i].exp_full  = (i + 1) == DEPTH;
    end
    gptr_at_full = 5'b11000;
    drain_full   = '{1'b1, 1'b1, 1'b0};
    drain_af     = '{1'b1, 1'b1, 1'b0};

    // Reset held with a push request and no clock edge yet.
    wr_rst_n          = 1'b1;
    bus.wr_req        = 1'b1;
    bus.wr_data_in    = '0;
    bus.ovf_clr       = 1'b0;
    bus.rd_gptr_async = '0;
    rd_ptr            = 0;
    model_reset();
    #1 wr_rst_n = 1'b0;
    #1 check_cleared("rst_hold");

    bus.wr_req = 1'b0;
    @(negedge wr_clk);
    wr_rst_n = 1'b1;
    clock_edge();
    for (int k = 0; k < 5; k++) begin
      apply(1'b0, '0, 1'b0);
      check_cleared("rst_idle");
      clock_edge();
    end

    // Fill from empty, table-driven.
    for (int i = 0; i < DEPTH; i++) begin
      apply(tbl[i].req, tbl[i].data, 1'b0);
      check("fill.wr_en",   32'(bus.wr_en),   32'(tbl[i].exp_en));
      check("fill.wr_addr", 32'(bus.wr_addr), 32'(tbl[i].exp_addr));
      check("fill.wr_data", 32'(bus.wr_data), 32'(tbl[i].data));
      clock_edge();
      check("fill.full",        32'(bus.full),        32'(tbl[i].exp_full));
      check("fill.almost_full", 32'(bus.almost_full), 32'(tbl[i].exp_af));
      check("fill.wr_level",    32'(bus.wr_level),    32'(tbl[i].exp_level));
    end
    check("fill.wr_gptr", 32'(bus.wr_gptr), 32'(gptr_at_full));

    // Pushes while full are rejected and set the sticky flag.
    for (int k = 0; k < 2; k++) begin
      apply(1'b1, 8'hFF, 1'b0);
      check("ovf.wr_en",   32'(bus.wr_en),   0);
      check("ovf.wr_addr", 32'(bus.wr_addr), 0);
      clock_edge();
      check("ovf.overflow", 32'(bus.overflow), 1);
      check("ovf.wr_level", 32'(bus.wr_level), DEPTH);
    end
    apply(1'b0, '0, 1'b1);
    clock_edge();
    check("ovf.clear", 32'(bus.overflow), 0);
    apply(1'b1, 8'hFF, 1'b1);
    clock_edge();
    check("ovf.set_wins", 32'(bus.overflow), 1);

    // Read pointer moves to 4: flags update on the third edge.
    rd_ptr = 4;
    for (int k = 0; k < 3; k++) begin
      apply(1'b0, '0, 1'b0);
      clock_edge();
      check("drain.full",        32'(bus.full),        32'(drain_full[k]));
      check("drain.almost_full", 32'(bus.almost_full), 32'(drain_af[k]));
    end
    check("drain.wr_level", 32'(bus.wr_level), 12);

    // Wrap run: reader trails the writer by four entries.
    seen_addr_wrap = 0;
    seen_ptr_wrap  = 0;
    seen_full      = 0;
    last_addr      = -1;
    prev_g         = bus.wr_gptr;
    for (int k = 0; k < 40; k++) begin
      rd_ptr = (m_wr - 4 + PMOD) % PMOD;
      apply(1'b1, 8'($urandom), 1'b0);
      check_model("wrap");
      if (last_addr == DEPTH - 1 && bus.wr_addr == '0) seen_addr_wrap = 1;
      last_addr = int'(bus.wr_addr);
      clock_edge();
      cur_g = bus.wr_gptr;
      check("wrap.gray_step", 32'($countones(cur_g ^ prev_g)), 1);
      if (prev_g == to_gray(PMOD - 1) && cur_g == '0) seen_ptr_wrap = 1;
      if (bus.full) seen_full = 1;
      prev_g = cur_g;
    end
    check("wrap.addr_wrap_seen", 32'(seen_addr_wrap), 1);
    check("wrap.ptr_wrap_seen",  32'(seen_ptr_wrap),  1);
    check("wrap.full_seen",      32'(seen_full),      0);

    // Randomised traffic: fast writer first, then fast reader.
    for (int k = 0; k < 400; k++) begin
      occ = (m_wr - rd_ptr + PMOD) % PMOD;
      if (occ > 0 && $urandom_range(0, 99) < (k < 200 ? 25 : 90)) rd_ptr = (rd_ptr + 1) % PMOD;
      apply($urandom_range(0, 99) < (k < 200 ? 75 : 40), 8'($urandom), $urandom_range(0, 9) == 0);
      check_model("rand");
      clock_edge();
    end

    // Reset in the middle of a burst.
    rd_ptr = m_wr;
    for (int k = 0; k < 3; k++) begin
      apply(1'b0, '0, 1'b0);
      clock_edge();
    end
    for (int k = 0; k < 6; k++) begin
      apply(1'b1, 8'h60 + 8'(k), 1'b0);
      check_model("burst");
      clock_edge();
    end
    apply(1'b1, 8'h77, 1'b0);
    check("burst7.wr_en", 32'(bus.wr_en), 1);
    #1 wr_rst_n = 1'b0;
    model_reset();
    rd_ptr = 0;
    bus.rd_gptr_async = '0;
    #1 check_cleared("rst_mid");
    bus.wr_req = 1'b0;
    #2 wr_rst_n = 1'b1;
    clock_edge();
    apply(1'b1, 8'h5A, 1'b0);
    check("rst_mid.first_en",   32'(bus.wr_en),   1);
    check("rst_mid.first_addr", 32'(bus.wr_addr), 0);
    clock_edge();
    check_model("rst_mid.after");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
